// File: rtl/nios_screen_reader_status_input.sv
// nios_screen_reader_status_input
//   Avalon-MM slave that lets the Nios II read an external status bus and
//   take interrupts on its edges. It provides a three-flop synchronizer, a
//   per-bit edge-capture register and an interrupt mask. A short start-up
//   guard after reset keeps the input levels present at reset release from
//   being captured as edges.
//
//   Optional feature macro: STATUS_INPUT_IRQ_EN
//     defined   : IRQMASK register (address 2) and the irq output are live.
//     undefined : address 2 reads 0 and ignores writes, and irq is tied to 0.
//                 EDGECAP still captures edges and can be cleared, so
//                 software polls it instead of taking interrupts.
//
// Parameters
//   WIDTH      width of in_port and of every register (1..32)
//   EDGE_TYPE  0 = rising, 1 = falling, 2 = any (other values act as 2)
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   address     register word address (0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAP)
//   chipselect  slave select; needed for writes only
//   write_n     active-low write strobe
//   writedata   write data; bits [WIDTH-1:0] are used
//   in_port     asynchronous external status bus
//   readdata    zero-latency, zero-extended read data
//   irq         level interrupt: |(EDGECAP & IRQMASK)
module nios_screen_reader_status_input #(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int ETYPE = (EDGE_TYPE == 0 || EDGE_TYPE == 1) ? EDGE_TYPE : 2;

    logic [WIDTH-1:0] s1, s2, s3;
    logic [1:0]       arm_cnt;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] cap_clr;
    logic             wr;

    // Only bits [WIDTH-1:0] of writedata are meaningful.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr = chipselect & ~write_n;

    // s1 is the metastability flop; s2 is the stable level and s3 is its
    // one-cycle-old copy used for edge detection.
    generate
        if (ETYPE == 0) begin : g_rise
            assign edge_raw = s2 & ~s3;
        end else if (ETYPE == 1) begin : g_fall
            assign edge_raw = ~s2 & s3;
        end else begin : g_any
            assign edge_raw = s2 ^ s3;
        end
    endgenerate

    // Until s1..s3 have all been loaded from in_port after reset, the
    // s2/s3 difference only reflects the reset zeros and is not an edge.
    assign edge_hit = (arm_cnt == 2'd3) ? edge_raw : '0;
    assign cap_clr  = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            arm_cnt <= '0;
            edgecap <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
            s3 <= s2;
            if (arm_cnt != 2'd3)
                arm_cnt <= arm_cnt + 2'd1;
            // A new edge takes priority over a clear in the same cycle.
            edgecap <= (edgecap & ~cap_clr) | edge_hit;
        end
    end

`ifdef STATUS_INPUT_IRQ_EN
    logic [WIDTH-1:0] irq_mask;

    always_ff @(posedge clk) begin
        if (reset)
            irq_mask <= '0;
        else if (wr && address == 2'd2)
            irq_mask <= writedata[WIDTH-1:0];
    end

    assign irq = |(edgecap & irq_mask);
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = s2;
`ifdef STATUS_INPUT_IRQ_EN
            2'd2:    readdata[WIDTH-1:0] = irq_mask;
`endif
            2'd3:    readdata[WIDTH-1:0] = edgecap;
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_nios_screen_reader_status_input.sv
module tb_nios_screen_reader_status_input;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nios_screen_reader_status_input #(.WIDTH(8), .EDGE_TYPE(0)) dut_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0));
    nios_screen_reader_status_input #(.WIDTH(8), .EDGE_TYPE(1)) dut_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1));
    nios_screen_reader_status_input #(.WIDTH(8), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2));

    // Reference model: the in_port value sampled at each clock edge since
    // the last reset is recorded; DATA and edge events follow from the
    // history by index arithmetic.
    logic [7:0] hist[$];
    logic [7:0] cap_m[3];
    logic [7:0] mask_m;

    function automatic logic [7:0] data_m();
        if (hist.size() >= 2) return hist[hist.size()-2];
        return 8'h00;
    endfunction

    function automatic logic [31:0] exp_rd(int t, logic [1:0] a);
        case (a)
            2'd0: return {24'h0, data_m()};
`ifdef STATUS_INPUT_IRQ_EN
            2'd2: return {24'h0, mask_m};
`endif
            2'd3: return {24'h0, cap_m[t]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic exp_irq(int t);
`ifdef STATUS_INPUT_IRQ_EN
        return |(cap_m[t] & mask_m);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, advance the model on the rising edge,
    // then compare all three instances 1 ns later.
    task automatic cyc(input logic r, input logic [1:0] a, input logic w,
                       input logic [31:0] d, input logic [7:0] p);
        int n;
        logic [7:0] cur, prv, e, clr;
        reset = r; address = a; writedata = d; in_port = p;
        if (w) begin
            chipselect = 1'b1; write_n = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
            chipselect = 1'b1; write_n = 1'b1;
        end else begin
            chipselect = 1'b0; write_n = 1'b0;
        end
        @(posedge clk);
        if (r) begin
            hist.delete();
            for (int t = 0; t < 3; t++) cap_m[t] = 8'h00;
            mask_m = 8'h00;
        end else begin
            n   = hist.size();
            clr = (w && a == 2'd3) ? d[7:0] : 8'h00;
            for (int t = 0; t < 3; t++) begin
                e = 8'h00;
                if (n >= 3) begin
                    cur = hist[n-2];
                    prv = hist[n-3];
                    e = (t == 0) ? (cur & ~prv) : (t == 1) ? (~cur & prv) : (cur ^ prv);
                end
                cap_m[t] = (cap_m[t] & ~clr) | e;
            end
            if (w && a == 2'd2) mask_m = d[7:0];
            hist.push_back(p);
        end
        #1;
        chk("rd_rise", rd0, exp_rd(0, a));
        chk("rd_fall", rd1, exp_rd(1, a));
        chk("rd_any",  rd2, exp_rd(2, a));
        chk("irq_rise", {31'h0, irq0}, {31'h0, exp_irq(0)});
        chk("irq_fall", {31'h0, irq1}, {31'h0, exp_irq(1)});
        chk("irq_any",  {31'h0, irq2}, {31'h0, exp_irq(2)});
        @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] p);
        cyc(1'b0, a, 1'b0, 32'h0, p);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [7:0] p);
        cyc(1'b0, a, 1'b1, d, p);
    endtask

    initial begin
        logic [7:0]  p;
        logic [1:0]  a;
        logic [31:0] d;
        int          hold;
        mask_m = 8'h00;
        for (int t = 0; t < 3; t++) cap_m[t] = 8'h00;
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'h0; in_port = 8'hFF;
        @(negedge clk);

        // Reset held with all inputs high: levels never become edges.
        for (int i = 0; i < 3; i++) cyc(1'b1, 2'(i), 1'b0, 32'h0, 8'hFF);
        chk("reset_irq", {31'h0, irq0}, 32'h0);
        for (int i = 0; i < 10; i++) rd(2'(i % 4), 8'hFF);
        rd(2'd0, 8'hFF);
        chk("hold_data", rd0, 32'h0000_00FF);
        rd(2'd3, 8'hFF);
        chk("hold_cap_any", rd2, 32'h0);
        chk("hold_irq_any", {31'h0, irq2}, 32'h0);

        // Rising edge on bit0 with mask 0x01.
        cyc(1'b1, 2'd0, 1'b0, 32'h0, 8'h00);
        for (int i = 0; i < 5; i++) rd(2'd0, 8'h00);
        wr(2'd2, 32'h01, 8'h00);
        rd(2'd0, 8'h01);
        rd(2'd0, 8'h01);
        chk("bit0_data", rd0, 32'h01);
        rd(2'd3, 8'h01);
        chk("bit0_cap", rd0, 32'h01);
        // Clear, then clear again while a new bit0 edge arrives.
        wr(2'd3, 32'h01, 8'h01);
        chk("bit0_clr", rd0, 32'h0);
        chk("bit0_clr_irq", {31'h0, irq0}, 32'h0);
        rd(2'd3, 8'h00);
        rd(2'd3, 8'h00);
        rd(2'd3, 8'h01);
        rd(2'd3, 8'h01);
        wr(2'd3, 32'h01, 8'h01);
        chk("edge_beats_clr", rd0, 32'h01);

        // Any-edge instance: bit3 pulse high then low, mask 0.
        cyc(1'b1, 2'd0, 1'b0, 32'h0, 8'h00);
        for (int i = 0; i < 4; i++) rd(2'd0, 8'h00);
        for (int i = 0; i < 4; i++) rd(2'd3, 8'h08);
        for (int i = 0; i < 4; i++) rd(2'd3, 8'h00);
        chk("bit3_any_cap", rd2, 32'h08);
        chk("bit3_any_irq", {31'h0, irq2}, 32'h0);
        wr(2'd2, 32'h08, 8'h00);
        rd(2'd3, 8'h00);

        // Mid-operation reset with pending edges, then an early edge.
        wr(2'd2, 32'hFF, 8'h0F);
        for (int i = 0; i < 4; i++) rd(2'd3, 8'h0F);
        cyc(1'b1, 2'd3, 1'b0, 32'h0, 8'h0F);
        chk("rst_cap", rd0, 32'h0);
        chk("rst_irq", {31'h0, irq0}, 32'h0);
        rd(2'd2, 8'h80);
        rd(2'd3, 8'h80);
        for (int i = 0; i < 5; i++) rd(2'd3, 8'h80);
        chk("early_edge_cap", rd0, 32'h0);

        // Bit7 rising edge, then mask write of 0xFF.
        for (int i = 0; i < 4; i++) rd(2'd3, 8'h00);
        for (int i = 0; i < 4; i++) rd(2'd3, 8'h80);
        chk("bit7_cap", rd0, 32'h80);
        wr(2'd2, 32'hFF, 8'h80);

        // Randomized traffic, including occasional resets.
        p = 8'h00; hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                p = p ^ 8'($urandom_range(0, 255));
                hold = $urandom_range(1, 4);
            end
            hold--;
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if ($urandom_range(0, 79) == 0)
                cyc(1'b1, a, 1'b0, d, p);
            else if ($urandom_range(0, 2) == 0)
                cyc(1'b0, a, 1'b1, d, p);
            else
                cyc(1'b0, a, 1'b0, d, p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_screen_reader_status_input.md
# nios_screen_reader_status_input

Avalon-MM slave input port that lets the Nios II read an external status bus (e.g. acquisition/trigger flags from the oscilloscope fabric) and take interrupts on its edges. It is the reader-side counterpart of the write-only PIO output registers on the same system interconnect. Includes input synchronization, per-bit edge capture, an interrupt mask, and a start-up guard against spurious edges after reset.

## Interface
- WIDTH, 8: width of `in_port` and of every register; 1..32.
- EDGE_TYPE, 0: edges captured; 0 = rising, 1 = falling, 2 = any.

- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- address  input  2  register word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data; bits [WIDTH-1:0] used.
- in_port  input  WIDTH  asynchronous external status bus.
- readdata  output  32  read data; zero-latency, upper bits zero.
- irq  output  1  level interrupt to the Nios II.

## Operation
- Register map (word addresses):
  - 0 DATA: read-only, synchronized `in_port`; writes ignored.
  - 1: reserved; reads 0, writes ignored.
  - 2 IRQMASK: read/write; bit i enables EDGECAP[i] onto `irq`.
  - 3 EDGECAP: read; write-1-to-clear per bit; write 0 leaves bit unchanged.
- Write occurs when chipselect=1, write_n=0 at a rising clk edge.
- readdata = zero-extended register selected by address, combinational; chipselect not required for read.
- Synchronizer: s1 <= in_port; s2 <= s1; s3 <= s2. DATA = s2.
- Edge detect per bit: rise = s2 & ~s3; fall = ~s2 & s3; edge selected by EDGE_TYPE.
- Start-up guard: 2-bit counter `arm_cnt` is cleared by reset and increments to 3, then saturates. Edge detection is enabled only when arm_cnt == 3. Input levels present at reset release are never captured as edges.
- EDGECAP[i] <= (EDGECAP[i] & ~clear[i]) | edge[i]. Simultaneous edge and clear: the edge wins, and the bit stays 1.
- irq = |(EDGECAP & IRQMASK), combinational from registers.
- EDGE_TYPE outside 0..2 is treated as 2.

## Timing
- Reset values: s1/s2/s3 = 0, arm_cnt = 0, IRQMASK = 0, EDGECAP = 0, irq = 0, readdata = 0 for all addresses.
- `in_port` change sampled at edge N: visible on DATA after edge N+1.
- EDGECAP bit sets after edge N+2; irq rises in that same cycle if the bit is masked in.
- Clear write at edge M: bit reads 0 and irq drops after edge M, unless an edge also arrives at M.
- IRQMASK write takes effect on irq the cycle after the write edge.
- Reset asserted mid-operation: all state returns to reset values at the next edge. The guard re-arms 3 cycles after reset deasserts.
- Pulses shorter than one clk period may be missed. Pulses of at least 2 clk periods are always captured.

## Configuration
- Macro STATUS_INPUT_IRQ_EN.
- Defined: IRQMASK register and `irq` output behave as specified above.
- Undefined:
  - IRQMASK is not implemented; address 2 reads 0 and writes are ignored.
  - `irq` is tied to 0.
  - EDGECAP still captures edges and is still readable and clearable (polling mode).

## Test plan
- Reset with in_port=8'hFF held, release, wait 10 cycles -> DATA=8'hFF, EDGECAP=0, irq=0.
- EDGE_TYPE=0, IRQMASK=8'h01, in_port 0->1 on bit0 -> DATA reads 1 after 2 edges; EDGECAP=8'h01 and irq=1 after 3 edges.
- Write 8'h01 to address 3 -> EDGECAP=0, irq=0 next cycle. Repeat with a bit0 edge on the same cycle -> EDGECAP stays 8'h01.
- EDGE_TYPE=2, toggle bit3 high then low (4 cycles each), IRQMASK=0 -> EDGECAP=8'h08, irq=0. Then write IRQMASK=8'h08 -> irq=1 the next cycle.
- Assert reset while EDGECAP=8'h0F and IRQMASK=8'hFF -> all registers read 0 and irq=0 after one edge. An edge within 2 cycles of release is not captured.
- Build without STATUS_INPUT_IRQ_EN: rising edge on bit7 -> EDGECAP=8'h80, irq stays 0, address 2 reads 0 after writing 8'hFF.
